// File: rtl/ltc_pkg.sv
// Shared encodings, sync word, parity positions and frame builder for the LTC transmit path.
// Pure declarations: no latency and no backpressure of its own.
package ltc_pkg;
    localparam logic [1:0]  FR_24 = 2'b00;
    localparam logic [1:0]  FR_25 = 2'b01;
    localparam logic [1:0]  FR_30 = 2'b11;
    localparam logic [15:0] SYNC_WORD = 16'b0011111111111101;
    localparam int          PAR_POS_2430 = 27;
    localparam int          PAR_POS_25 = 59;
    localparam logic [6:0]  LAST_BIT = 7'd79;

    typedef enum logic {IDLE, RUN} state_t;

    // Sync word is written MSB-first but bit 64 is sent first, hence the reversal.
    function automatic logic [79:0] build_frame(input logic [63:0] data, input logic [1:0] fr);
        logic [63:0] d;
        logic [15:0] sync_rev;
        d = data;
        if (fr == FR_24 || fr == FR_30) begin
            d[PAR_POS_2430] = 1'b0;
            d[PAR_POS_2430] = ~^d;
        end else begin
            d[PAR_POS_25] = 1'b0;
            d[PAR_POS_25] = ~^d;
        end
        for (int i = 0; i < 16; i++) begin
            sync_rev[i] = SYNC_WORD[15-i];
        end
        return {sync_rev, d};
    endfunction
endpackage

// File: rtl/ltc_bmc_encoder.sv
// Biphase-mark line driver: toggles at every bit start and mid-bit for ones.
// Latency: output changes on the edge after a tick; no backpressure.
module ltc_bmc_encoder (
    input  logic clk,
    input  logic reset_n,
    input  logic bit_tick,
    input  logic mid_tick,
    input  logic bit_val,
    output logic ltc_out
);
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ltc_out <= 1'b0;
        end else if (bit_tick || (mid_tick && bit_val)) begin
            ltc_out <= ~ltc_out;
        end
    end
endmodule

// File: rtl/ltc_tx_sequencer.sv
// LTC frame scheduler: one-entry shadow buffer, parity/sync insertion, half-bit timing.
// Latency: frame loads one edge after the shadow fills in IDLE; backpressure via frame_ready while shadow full.
module ltc_tx_sequencer
    import ltc_pkg::*;
#(
    parameter int HB_24 = 3125,
    parameter int HB_25 = 3000,
    parameter int HB_30 = 2500
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [1:0]  framerate,
    input  logic [63:0] frame_data,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic        frame_start,
    output logic [6:0]  bit_index,
    output logic        busy,
    output logic        underrun,
    input  logic        underrun_clr,
    output logic        ltc_out
);
    state_t      state, state_nxt;
    logic        shadow_full;
    logic [63:0] shadow_dat;
    logic [63:0] last_dat;
    logic [63:0] load_dat;
    logic [79:0] shreg;
    logic [1:0]  rate_lat;
    logic [15:0] hb_cnt;
    logic        half;
    logic [6:0]  bit_idx;
    logic        frame_start_q;
    logic        underrun_q;
    logic        hb_last;
    logic        mid_tick, bit_wrap, frame_end, load, retx, bit_tick;

    function automatic logic [15:0] hb_of(input logic [1:0] fr);
        case (fr)
            FR_24:   return 16'(HB_24);
            FR_30:   return 16'(HB_30);
            default: return 16'(HB_25);
        endcase
    endfunction

    assign hb_last     = (hb_cnt == hb_of(rate_lat) - 16'd1);
    assign load_dat    = shadow_full ? shadow_dat : last_dat;
    assign frame_ready = ~shadow_full;
    assign frame_start = frame_start_q;
    assign bit_index   = bit_idx;
    assign underrun    = underrun_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en && shadow_full) state_nxt = RUN;
            RUN:     if (frame_end && !en)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == RUN);
        mid_tick  = busy && hb_last && !half;
        bit_wrap  = busy && hb_last && half;
        frame_end = bit_wrap && (bit_idx == LAST_BIT);
        load      = (state == IDLE && en && shadow_full) || (frame_end && en);
        retx      = frame_end && en && !shadow_full;
        bit_tick  = load || (bit_wrap && bit_idx != LAST_BIT);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow_full   <= 1'b0;
            shadow_dat    <= '0;
            last_dat      <= '0;
            shreg         <= '0;
            rate_lat      <= FR_24;
            hb_cnt        <= '0;
            half          <= 1'b0;
            bit_idx       <= '0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            // A retransmit boundary may accept a fresh word in the same edge.
            if (frame_valid && !shadow_full) begin
                shadow_full <= 1'b1;
                shadow_dat  <= frame_data;
            end else if (load) begin
                shadow_full <= 1'b0;
            end
            frame_start_q <= load;
            if (load) begin
                shreg    <= build_frame(load_dat, framerate);
                last_dat <= load_dat;
                rate_lat <= framerate;
                hb_cnt   <= '0;
                half     <= 1'b0;
                bit_idx  <= '0;
            end else if (state == RUN) begin
                if (hb_last) begin
                    hb_cnt <= '0;
                    half   <= ~half;
                    if (half && bit_idx != LAST_BIT) begin
                        bit_idx <= bit_idx + 7'd1;
                        shreg   <= {1'b0, shreg[79:1]};
                    end
                end else begin
                    hb_cnt <= hb_cnt + 16'd1;
                end
            end
            if (retx) begin
                underrun_q <= 1'b1;
            end else if (underrun_clr) begin
                underrun_q <= 1'b0;
            end
        end
    end

    ltc_bmc_encoder u_bmc (
        .clk      (clk),
        .reset_n  (reset_n),
        .bit_tick (bit_tick),
        .mid_tick (mid_tick),
        .bit_val  (shreg[0]),
        .ltc_out  (ltc_out)
    );
endmodule

// File: tb/tb_ltc_tx_sequencer.sv
// Directed/randomized bench for ltc_tx_sequencer with a frame-level behavioural model.
// Half-bit lengths are shortened so whole frames fit in a short run.
module tb_ltc_tx_sequencer;
    localparam int HB24 = 6;
    localparam int HB25 = 5;
    localparam int HB30 = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  framerate = 2'b00;
    logic [63:0] frame_data = '0;
    logic        frame_valid = 1'b0;
    logic        underrun_clr = 1'b0;
    logic        frame_ready, frame_start, busy, underrun, ltc_out;
    logic [6:0]  bit_index;

    int          tests = 0;
    int          fails = 0;
    logic        m_full = 1'b0;
    logic        m_ur = 1'b0;
    logic        m_clr_pend = 1'b0;
    logic [63:0] m_word = '0;
    logic [63:0] m_last = '0;
    logic        ltc_prev = 1'b0;

    always #5 clk = ~clk;

    ltc_tx_sequencer #(.HB_24(HB24), .HB_25(HB25), .HB_30(HB30)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .framerate    (framerate),
        .frame_data   (frame_data),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_start  (frame_start),
        .bit_index    (bit_index),
        .busy         (busy),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .ltc_out      (ltc_out)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        ltc_prev = ltc_out;
        @(negedge clk);
    endtask

    function automatic int hb_of(input logic [1:0] r);
        if (r == 2'b00) return HB24;
        if (r == 2'b11) return HB30;
        return HB25;
    endfunction

    // Frame = data with the parity slot chosen so the whole 80-bit frame has even weight.
    function automatic logic [79:0] ref_frame(input logic [63:0] w, input logic [1:0] r);
        logic [79:0] f;
        int pos, ones;
        pos = (r == 2'b00 || r == 2'b11) ? 27 : 59;
        f = '0;
        f[63:0] = w;
        f[pos] = 1'b0;
        for (int i = 66; i <= 77; i++) f[i] = 1'b1;
        f[79] = 1'b1;
        ones = 0;
        for (int i = 0; i < 80; i++) ones += int'(f[i]);
        f[pos] = (ones % 2 == 1);
        return f;
    endfunction

    task automatic wait_start(input string tag);
        int k = 0;
        while (frame_start !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        chk({tag, "_start_seen"}, frame_start, 1);
    endtask

    task automatic push_word(input string tag, input logic [63:0] w);
        int k = 0;
        frame_valid = 1'b1;
        frame_data  = w;
        while (frame_ready !== 1'b1 && k < 2000) begin
            step();
            k++;
        end
        chk({tag, "_ready_wait"}, frame_ready, 1);
        step();
        m_full = 1'b1;
        m_word = w;
        chk({tag, "_ready_fall"}, frame_ready, 0);
        frame_valid = 1'b0;
    endtask

    // Entered at the negedge where frame_start is high; leaves one frame length later.
    task automatic run_frame(input string tag, input int push_at, input logic [63:0] push_w,
                             input int en_off_at, input int rate_at, input logic [1:0] new_rate,
                             input int clr_at, output logic fs_next, output logic ur_clr,
                             output int first_chg);
        logic [63:0]  w;
        logic [1:0]   r;
        logic [79:0]  f;
        logic [159:0] exp_lv, obs_a, obs_b;
        logic         lvl, l0, acc_pend;
        int           hb, n, fs_err, bi_err, busy_err;
        r  = framerate;
        hb = hb_of(r);
        n  = 160 * hb;
        if (m_full) begin
            w = m_word;
            m_full = 1'b0;
            if (m_clr_pend) m_ur = 1'b0;
        end else begin
            w = m_last;
            m_ur = 1'b1;
        end
        m_clr_pend = 1'b0;
        m_last = w;
        f = ref_frame(w, r);
        lvl = ltc_prev;
        for (int b = 0; b < 80; b++) begin
            lvl = ~lvl;
            exp_lv[2*b] = lvl;
            if (f[b]) lvl = ~lvl;
            exp_lv[2*b+1] = lvl;
        end
        chk({tag, "_start_underrun"}, underrun, m_ur);
        chk({tag, "_start_ready"}, frame_ready, 1);
        chk({tag, "_start_bitidx"}, bit_index, 0);
        obs_a = '0; obs_b = '0;
        fs_err = 0; bi_err = 0; busy_err = 0;
        first_chg = -1;
        l0 = ltc_out;
        acc_pend = 1'b0;
        fs_next = 1'b0;
        ur_clr = 1'bx;
        for (int c = 0; c <= n; c++) begin
            if (c > 0) step();
            if (c == clr_at + 1) begin
                ur_clr = underrun;
                underrun_clr = 1'b0;
                if (c < n) m_ur = 1'b0;
                else m_clr_pend = 1'b1;
            end
            if (c == n) begin
                fs_next = frame_start;
                break;
            end
            if (c % hb == 0) obs_a[c / hb] = ltc_out;
            if (c % hb == hb - 1) obs_b[c / hb] = ltc_out;
            if (c > 0 && frame_start !== 1'b0) fs_err++;
            if (int'(bit_index) != c / (2 * hb)) bi_err++;
            if (busy !== 1'b1) busy_err++;
            if (first_chg < 0 && ltc_out !== l0) first_chg = c;
            if (acc_pend) begin
                chk({tag, "_ready_fall"}, frame_ready, 0);
                frame_valid = 1'b0;
                acc_pend = 1'b0;
            end
            if (c == n - 1) chk({tag, "_ready_at_end"}, frame_ready, !m_full);
            if (c == push_at) begin
                frame_valid = 1'b1;
                frame_data  = push_w;
            end
            if (c == en_off_at) en = 1'b0;
            if (c == rate_at) framerate = new_rate;
            if (c == clr_at) underrun_clr = 1'b1;
            if (frame_valid && frame_ready) begin
                acc_pend = 1'b1;
                m_full = 1'b1;
                m_word = frame_data;
            end
        end
        chk({tag, "_levels_first"}, obs_a, exp_lv);
        chk({tag, "_levels_last"}, obs_b, exp_lv);
        chk({tag, "_no_extra_start"}, fs_err, 0);
        chk({tag, "_bit_index"}, bi_err, 0);
        chk({tag, "_busy"}, busy_err, 0);
    endtask

    initial begin
        logic        fs, urc, l0;
        int          fc, cnt;
        logic [63:0] w_r1, w2, w5, w7, w8, w9, w10;
        w_r1 = {$urandom, $urandom};
        w2   = ({$urandom, $urandom} & ~64'hF) | 64'h5;
        w5   = {$urandom, $urandom};
        w7   = {$urandom, $urandom};
        w8   = {$urandom, $urandom};
        w9   = {$urandom, $urandom};
        w10  = {$urandom, $urandom};

        for (int i = 0; i < 3; i++) step();
        chk("rst_ltc", ltc_out, 0);
        chk("rst_ready", frame_ready, 1);
        chk("rst_fs", frame_start, 0);
        chk("rst_bitidx", bit_index, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        reset_n = 1'b1;
        step();

        // 24 fps, all-zero word, second word supplied mid-frame
        en = 1'b1;
        framerate = 2'b00;
        push_word("t1_push", 64'h0);
        wait_start("t1");
        run_frame("t1_f1", 100, w_r1, -1, -1, 2'b00, -1, fs, urc, fc);
        chk("t1_first_transition", fc, 2 * HB24);
        chk("t3_back_to_back", fs, 1);
        run_frame("t3_f2", 100, w2, -1, 300, 2'b01, -1, fs, urc, fc);
        chk("t2_back_to_back", fs, 1);

        // 25 fps, frames-units = 5, then let the shadow run dry
        run_frame("t2_f3", -1, '0, -1, -1, 2'b01, -1, fs, urc, fc);
        chk("t2_first_transition", fc, HB25);
        chk("t4_retx_start", fs, 1);
        run_frame("t4_f4", -1, '0, -1, -1, 2'b01, 160 * HB25 - 1, fs, urc, fc);
        chk("t4_set_beats_clr", urc, 1);
        chk("t4_retx2_start", fs, 1);
        run_frame("t4_f5", 200, w5, -1, -1, 2'b01, 50, fs, urc, fc);
        chk("t4_lone_clr", urc, 0);
        chk("t5_f6_start", fs, 1);

        // en dropped at bit 40: frame completes then idles
        run_frame("t5_f6", -1, '0, 40 * 2 * HB25, -1, 2'b01, -1, fs, urc, fc);
        chk("t5_no_restart", fs, 0);
        chk("t5_busy_low", busy, 0);
        push_word("t5_idle_push", w7);
        l0 = ltc_out;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (ltc_out !== l0 || busy !== 1'b0 || frame_start !== 1'b0) cnt++;
        end
        chk("t5_idle_stable", cnt, 0);

        // rate change 24 -> 30 mid-frame, then reset during the next frame
        framerate = 2'b00;
        en = 1'b1;
        wait_start("t6");
        run_frame("t6_f7", 400, w8, -1, 300, 2'b11, -1, fs, urc, fc);
        chk("t6_f8_start", fs, 1);
        run_frame("t6_f8", 100, w9, -1, -1, 2'b11, -1, fs, urc, fc);
        chk("t6_f9_start", fs, 1);
        m_full = 1'b0;
        m_last = w9;
        for (int i = 0; i < 20; i++) step();
        push_word("t6_push", w10);
        reset_n = 1'b0;
        step();
        chk("t6_rst_ltc", ltc_out, 0);
        chk("t6_rst_ready", frame_ready, 1);
        chk("t6_rst_fs", frame_start, 0);
        chk("t6_rst_bitidx", bit_index, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_underrun", underrun, 0);
        reset_n = 1'b1;
        m_full = 1'b0;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (frame_start !== 1'b0 || busy !== 1'b0 || frame_ready !== 1'b1) cnt++;
        end
        chk("t6_shadow_discarded", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
